// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide memory between fetch and data requesters; each grant runs 8 big-endian byte beats.
// Define ARB_ROUND_ROBIN_EN to alternate grants on conflict instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int MEM_AW     = 8,
  parameter int WORD_BYTES = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  output logic              if_ack,
  output logic [63:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              grant_d
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BEAT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [2:0] LAST_BEAT = 3'(WORD_BYTES - 1);

  logic [1:0]  state;
  logic [2:0]  beat;
  logic        we_q;
  logic        last_d;
  logic        pick_d;
  logic        we_r;
  logic [63:0] wdata_r;
  logic [63:0] word_acc;
  logic        unused_addr_hi;

  function automatic logic [7:0] pick_byte(input logic [63:0] w, input logic [2:0] k);
    return w[8*(7-int'(k)) +: 8];
  endfunction

  assign unused_addr_hi = ^{if_addr[63:MEM_AW], d_addr[63:MEM_AW]};

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_req && (!if_req || !last_d);
`else
    pick_d = d_req;
`endif
  end

  // The strobe is cut by reset so a beat abandoned mid-cycle never reaches the array.
  assign mem_we = we_q && reset;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      beat      <= 3'd0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      we_q      <= 1'b0;
      grant_d   <= 1'b0;
      last_d    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_req || d_req) begin
            grant_d   <= pick_d;
            mem_addr  <= pick_d ? d_addr[MEM_AW-1:0] : if_addr[MEM_AW-1:0];
            we_q      <= pick_d && d_we;
            mem_wdata <= pick_d ? d_wdata[63:56] : 8'd0;
            beat      <= 3'd0;
            state     <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          beat <= beat + 3'd1;
          if (beat == LAST_BEAT) begin
            state <= ST_DONE;
            we_q  <= 1'b0;
            if (grant_d) d_ack  <= 1'b1;
            else         if_ack <= 1'b1;
            if (!we_r) begin
              if (grant_d) d_rdata  <= {word_acc[63:8], mem_rdata};
              else         if_rdata <= {word_acc[63:8], mem_rdata};
            end
          end else begin
            mem_addr  <= mem_addr + MEM_AW'(1);
            mem_wdata <= pick_byte(wdata_r, beat + 3'd1);
          end
        end
        ST_DONE: begin
          last_d <= grant_d;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Transfer payload registers carry no reset; they are always loaded at grant before use.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && (if_req || d_req)) begin
      we_r    <= pick_d && d_we;
      wdata_r <= pick_d ? d_wdata : 64'd0;
    end
    if (state == ST_BEAT && !we_r)
      word_acc[8*(7-int'(beat)) +: 8] <= mem_rdata;
  end

endmodule
